// File: rtl/fft_pkg.sv
// Shared FFT-path definitions: Q16.16 constants, twiddles and the frame FSM states.
package fft_pkg;

  localparam int DW   = 32;
  localparam int FRAC = 16;

  localparam logic signed [31:0] ONE = 32'h00010000;

  // W0 = 1 + j0, W4 = 0 - j1 (Q16.16)
  localparam logic signed [31:0] W0_RE = 32'h00010000;
  localparam logic signed [31:0] W0_IM = 32'h00000000;
  localparam logic signed [31:0] W4_RE = 32'h00000000;
  localparam logic signed [31:0] W4_IM = 32'hFFFF0000;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

endpackage

// File: rtl/butterfly_4_point.sv
// Combinational 4-point radix-2 butterfly stage on Q16.16 complex samples.
// a0 pairs x0/x2 with W0 (=1), a1 pairs x1/x3 with W4 (=-j).
// All sums wrap; the twiddle product truncates the Q32.32 result back to Q16.16.
module butterfly_4_point #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] x0_re,
  input  logic [DW-1:0] x0_im,
  input  logic [DW-1:0] x1_re,
  input  logic [DW-1:0] x1_im,
  input  logic [DW-1:0] x2_re,
  input  logic [DW-1:0] x2_im,
  input  logic [DW-1:0] x3_re,
  input  logic [DW-1:0] x3_im,
  output logic [DW-1:0] y0_re,
  output logic [DW-1:0] y0_im,
  output logic [DW-1:0] y1_re,
  output logic [DW-1:0] y1_im,
  output logic [DW-1:0] y2_re,
  output logic [DW-1:0] y2_im,
  output logic [DW-1:0] y3_re,
  output logic [DW-1:0] y3_im
);
  import fft_pkg::*;

  localparam logic signed [DW-1:0] TW0_RE = W0_RE;
  localparam logic signed [DW-1:0] TW0_IM = W0_IM;
  localparam logic signed [DW-1:0] TW4_RE = W4_RE;
  localparam logic signed [DW-1:0] TW4_IM = W4_IM;

  // Q16.16 x Q16.16 -> Q16.16, truncating fraction bits, wrapping integer bits
  function automatic logic signed [DW-1:0] q_mul(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    return DW'(p >>> FRAC);
  endfunction

  function automatic logic signed [DW-1:0] cmul_re(input logic signed [DW-1:0] dr,
                                                   input logic signed [DW-1:0] di,
                                                   input logic signed [DW-1:0] wr,
                                                   input logic signed [DW-1:0] wi);
    return q_mul(dr, wr) - q_mul(di, wi);
  endfunction

  function automatic logic signed [DW-1:0] cmul_im(input logic signed [DW-1:0] dr,
                                                   input logic signed [DW-1:0] di,
                                                   input logic signed [DW-1:0] wr,
                                                   input logic signed [DW-1:0] wi);
    return q_mul(dr, wi) + q_mul(di, wr);
  endfunction

  logic signed [DW-1:0] d02_re, d02_im, d13_re, d13_im;

  // Butterfly sums and twiddled differences
  always_comb begin
    d02_re = x0_re - x2_re;
    d02_im = x0_im - x2_im;
    d13_re = x1_re - x3_re;
    d13_im = x1_im - x3_im;

    y0_re = x0_re + x2_re;
    y0_im = x0_im + x2_im;
    y2_re = cmul_re(d02_re, d02_im, TW0_RE, TW0_IM);
    y2_im = cmul_im(d02_re, d02_im, TW0_RE, TW0_IM);

    y1_re = x1_re + x3_re;
    y1_im = x1_im + x3_im;
    y3_re = cmul_re(d13_re, d13_im, TW4_RE, TW4_IM);
    y3_im = cmul_im(d13_re, d13_im, TW4_RE, TW4_IM);
  end

endmodule

// File: rtl/fft4_frame_ctrl.sv
// Frame sequencer around butterfly_4_point: gathers four input samples,
// latches the butterfly results for one cycle, then replays them serially
// under valid/ready backpressure.
module fft4_frame_ctrl #(
  parameter int DW  = 32,
  parameter int FCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [DW-1:0]  in_real,
  input  logic [DW-1:0]  in_imag,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_real,
  output logic [DW-1:0]  out_imag,
  output logic [1:0]     out_index,
  output logic           out_last,
  output logic [FCW-1:0] frame_cnt
);
  import fft_pkg::*;

  state_t state, state_nx;

  logic [1:0]    wr_idx;
  logic [1:0]    rd_idx;
  logic [DW-1:0] d_re [4];
  logic [DW-1:0] d_im [4];
  logic [DW-1:0] f_re [4];
  logic [DW-1:0] f_im [4];
  logic [DW-1:0] b_re [4];
  logic [DW-1:0] b_im [4];
  logic          in_hs;
  logic          out_hs;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  butterfly_4_point #(.DW(DW)) u_bfly (
    .x0_re(d_re[0]), .x0_im(d_im[0]),
    .x1_re(d_re[1]), .x1_im(d_im[1]),
    .x2_re(d_re[2]), .x2_im(d_im[2]),
    .x3_re(d_re[3]), .x3_im(d_im[3]),
    .y0_re(b_re[0]), .y0_im(b_im[0]),
    .y1_re(b_re[1]), .y1_im(b_im[1]),
    .y2_re(b_re[2]), .y2_im(b_im[2]),
    .y3_re(b_re[3]), .y3_im(b_im[3])
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and output presentation
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_real  = '0;
    out_imag  = '0;
    out_index = 2'd0;
    out_last  = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && wr_idx == 2'd3) state_nx = COMPUTE;
      end
      COMPUTE: begin
        state_nx = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_real  = f_re[rd_idx];
        out_imag  = f_im[rd_idx];
        out_index = rd_idx;
        out_last  = (rd_idx == 2'd3);
        if (out_ready && rd_idx == 2'd3) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // Input slot capture; wr_idx wraps 3 -> 0 on the frame-closing sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        d_re[i] <= '0;
        d_im[i] <= '0;
      end
    end else if (in_hs) begin
      wr_idx       <= wr_idx + 2'd1;
      d_re[wr_idx] <= in_real;
      d_im[wr_idx] <= in_imag;
    end
  end

  // Butterfly results latched during the single COMPUTE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        f_re[i] <= '0;
        f_im[i] <= '0;
      end
    end else if (state == COMPUTE) begin
      for (int i = 0; i < 4; i++) begin
        f_re[i] <= b_re[i];
        f_im[i] <= b_im[i];
      end
    end
  end

  // Output read pointer and completed-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx    <= 2'd0;
      frame_cnt <= '0;
    end else if (state == COMPUTE) begin
      rd_idx <= 2'd0;
    end else if (out_hs) begin
      rd_idx <= rd_idx + 2'd1;
      if (rd_idx == 2'd3) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// Self-checking bench for fft4_frame_ctrl: directed frames plus randomized
// valid/ready traffic, compared against a frame-level reference model.
module tb_fft4_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_real, in_imag;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_real, out_imag;
  logic [1:0]  out_index;
  logic        out_last;
  logic [7:0]  frame_cnt;

  fft4_frame_ctrl #(.DW(32), .FCW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .out_last(out_last), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] in_q_re[$], in_q_im[$];
  logic [31:0] exp_re[$], exp_im[$];
  int          exp_idx[$];
  logic [7:0]  fcnt_m = 0;
  int          t4 = -10;
  bit          prev_hold = 0;
  logic [31:0] prev_re, prev_im;
  logic [1:0]  prev_idx;
  logic [31:0] rec_re[4], rec_im[4];
  bit          period_en = 0;
  int          last_first = -1;

  function automatic void model_frame();
    logic [31:0] f_re[4], f_im[4];
    logic [31:0] dr, di;
    f_re[0] = in_q_re[0] + in_q_re[2];
    f_im[0] = in_q_im[0] + in_q_im[2];
    f_re[2] = in_q_re[0] - in_q_re[2];
    f_im[2] = in_q_im[0] - in_q_im[2];
    f_re[1] = in_q_re[1] + in_q_re[3];
    f_im[1] = in_q_im[1] + in_q_im[3];
    dr = in_q_re[1] - in_q_re[3];
    di = in_q_im[1] - in_q_im[3];
    f_re[3] = di;          // (dr + j di) * (-j) = di - j dr
    f_im[3] = 32'd0 - dr;
    for (int k = 0; k < 4; k++) begin
      exp_re.push_back(f_re[k]);
      exp_im.push_back(f_im[k]);
      exp_idx.push_back(k);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_index", out_index, 0);
      check_val("rst_out_last", out_last, 0);
      check_val("rst_out_real", out_real, 0);
      check_val("rst_out_imag", out_imag, 0);
      check_val("rst_frame_cnt", frame_cnt, 0);
      in_q_re.delete(); in_q_im.delete();
      exp_re.delete(); exp_im.delete(); exp_idx.delete();
      fcnt_m = 0; t4 = -10; prev_hold = 0; last_first = -1;
    end else begin
      check_val("in_ready", in_ready, exp_re.size() == 0);
      check_val("out_valid", out_valid, (exp_re.size() != 0) && (cyc != t4 + 1));
      check_val("frame_cnt", frame_cnt, fcnt_m);
      if (prev_hold) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_real", out_real, prev_re);
        check_val("hold_imag", out_imag, prev_im);
        check_val("hold_index", out_index, prev_idx);
      end
      if (out_valid && exp_re.size() != 0) begin
        check_val("out_real", out_real, exp_re[0]);
        check_val("out_imag", out_imag, exp_im[0]);
        check_val("out_index", out_index, exp_idx[0]);
        check_val("out_last", out_last, exp_idx[0] == 3);
        if (out_ready) begin
          rec_re[exp_idx[0]] = out_real;
          rec_im[exp_idx[0]] = out_imag;
          if (exp_idx[0] == 0) begin
            if (period_en && last_first >= 0) check_val("period", cyc - last_first, 9);
            last_first = cyc;
          end
          if (exp_idx[0] == 3) fcnt_m = fcnt_m + 8'd1;
          void'(exp_re.pop_front()); void'(exp_im.pop_front()); void'(exp_idx.pop_front());
        end
      end else if (!out_valid) begin
        check_val("idle_last", out_last, 0);
      end
      prev_hold = out_valid && !out_ready;
      prev_re = out_real; prev_im = out_imag; prev_idx = out_index;
      if (in_valid && in_ready) begin
        in_q_re.push_back(in_real);
        in_q_im.push_back(in_imag);
        if (in_q_re.size() == 4) begin
          model_frame();
          t4 = cyc;
          in_q_re.delete(); in_q_im.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [31:0] re, input logic [31:0] im);
    int n = 0;
    in_valid = 1'b1; in_real = re; in_imag = im;
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    if (!in_ready) check_val("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(in_ready && !out_valid) && n < 200) begin n++; @(negedge clk); end
    if (!(in_ready && !out_valid)) check_val("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_index(input logic [1:0] idx);
    int n = 0;
    @(negedge clk);
    while (!(out_valid && out_index == idx) && n < 100) begin n++; @(negedge clk); end
    if (!(out_valid && out_index == idx)) check_val("index_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  int acc;
  int nlast;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // Impulse in slot 0
    push(32'h00010000, 0); push(0, 0); push(0, 0); push(0, 0);
    wait_idle();
    check_val("imp_re0", rec_re[0], 32'h00010000);
    check_val("imp_im0", rec_im[0], 0);
    check_val("imp_re1", rec_re[1], 0);
    check_val("imp_re2", rec_re[2], 32'h00010000);
    check_val("imp_im2", rec_im[2], 0);
    check_val("imp_re3", rec_re[3], 0);
    check_val("imp_cnt", frame_cnt, 1);

    // Impulse in slot 1
    push(0, 0); push(32'h00010000, 0); push(0, 0); push(0, 0);
    wait_idle();
    check_val("s1_re0", rec_re[0], 0);
    check_val("s1_re1", rec_re[1], 32'h00010000);
    check_val("s1_im1", rec_im[1], 0);
    check_val("s1_re2", rec_re[2], 0);
    check_val("s1_re3", rec_re[3], 0);
    check_val("s1_im3", rec_im[3], 32'hFFFF0000);
    check_val("s1_cnt", frame_cnt, 2);

    // Backpressure at index 2
    for (int i = 0; i < 4; i++) push($urandom, $urandom);
    wait_index(2'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_val("bp_index", out_index, 2);
      check_val("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();
    check_val("bp_cnt", frame_cnt, 3);

    // Input gaps
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i][0]; in_real = $urandom; in_imag = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_val("gap_accepts", acc, 4);
    wait_idle();

    // Reset in the middle of EMIT, then a fresh frame
    for (int i = 0; i < 4; i++) push($urandom, $urandom);
    wait_index(2'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push($urandom, $urandom);
    wait_idle();
    check_val("post_rst_cnt", frame_cnt, 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_real = $urandom; in_imag = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();

    // 256 back-to-back frames: 9-cycle period and counter wrap
    do_reset();
    period_en = 1;
    in_valid = 1'b1; out_ready = 1'b1;
    nlast = 0;
    while (nlast < 256 && cyc < 60000) begin
      in_real = $urandom; in_imag = $urandom;
      @(negedge clk);
      if (out_valid && out_ready && out_last) nlast++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_val("wrap_frames", nlast, 256);
    check_val("wrap_cnt", frame_cnt, 0);
    period_en = 0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
